// File: rtl/compare_feeder.sv
// Streams two NWORDS x iW operand buffers, least significant word first, into a
// serial comparator and latches the comparator's verdict as a one-cycle result.
module compare_feeder #(
    parameter int iW     = 32,
    parameter int NWORDS = 64
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          iLoadValid,
    input  logic          iLoadSel,
    input  logic [5:0]    iLoadAddr,
    input  logic [iW-1:0] iLoadData,
    input  logic          iStart,
    output logic          oBusy,
    output logic          oCmpEnable,
    output logic [iW-1:0] oCmpDataX,
    output logic [iW-1:0] oCmpDataY,
    input  logic [2:0]    iCmpMode,
    output logic          oResultValid,
    output logic [1:0]    oResult,
    output logic          oError
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [6:0] LAST = 7'(NWORDS);

    state_t        state;
    logic [6:0]    cnt;
    logic [6:0]    nxt;
    logic          loadEn;
    logic [iW-1:0] firstX;
    logic [iW-1:0] firstY;
    logic [iW-1:0] bufX [NWORDS];
    logic [iW-1:0] bufY [NWORDS];

    assign loadEn = iLoadValid && (state == IDLE);
    assign nxt    = cnt + 7'd1;

    // A load to word 0 on the accepting edge must already be visible in RUN cycle 0.
    assign firstX = (loadEn && !iLoadSel && iLoadAddr == 6'd0) ? iLoadData : bufX[0];
    assign firstY = (loadEn &&  iLoadSel && iLoadAddr == 6'd0) ? iLoadData : bufY[0];

    // Operand storage deliberately survives reset.
    always_ff @(posedge iClk) begin
        if (loadEn) begin
            if (iLoadSel) bufY[iLoadAddr] <= iLoadData;
            else          bufX[iLoadAddr] <= iLoadData;
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state        <= IDLE;
            cnt          <= '0;
            oBusy        <= 1'b0;
            oCmpEnable   <= 1'b0;
            oCmpDataX    <= '0;
            oCmpDataY    <= '0;
            oResultValid <= 1'b0;
            oResult      <= 2'b00;
            oError       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oResultValid <= 1'b0;
                    if (iStart) begin
                        state      <= RUN;
                        cnt        <= '0;
                        oBusy      <= 1'b1;
                        oCmpEnable <= 1'b1;
                        oCmpDataX  <= firstX;
                        oCmpDataY  <= firstY;
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        state        <= DONE;
                        oCmpEnable   <= 1'b0;
                        oCmpDataX    <= '0;
                        oCmpDataY    <= '0;
                        oResultValid <= 1'b1;
                        case (iCmpMode)
                            3'b010:  begin oResult <= 2'b10; oError <= 1'b0; end
                            3'b001:  begin oResult <= 2'b01; oError <= 1'b0; end
                            3'b011:  begin oResult <= 2'b11; oError <= 1'b0; end
                            default: begin oResult <= 2'b00; oError <= 1'b1; end
                        endcase
                    end else begin
                        cnt <= nxt;
                        // The final cycle only waits for the verdict; its data is don't-care.
                        if (nxt < LAST) begin
                            oCmpDataX <= bufX[nxt[5:0]];
                            oCmpDataY <= bufY[nxt[5:0]];
                        end else begin
                            oCmpDataX <= '0;
                            oCmpDataY <= '0;
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    oBusy        <= 1'b0;
                    oResultValid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_compare_feeder.sv
// Directed and randomized checks of compare_feeder against a word-array reference
// model, with a behavioural serial comparator closing the loop.
module tb_compare_feeder;

    localparam int W  = 32;
    localparam int NW = 64;

    logic          iClk = 1'b0;
    logic          iReset;
    logic          iLoadValid;
    logic          iLoadSel;
    logic [5:0]    iLoadAddr;
    logic [W-1:0]  iLoadData;
    logic          iStart;
    logic          oBusy;
    logic          oCmpEnable;
    logic [W-1:0]  oCmpDataX;
    logic [W-1:0]  oCmpDataY;
    logic [2:0]    iCmpMode;
    logic          oResultValid;
    logic [1:0]    oResult;
    logic          oError;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] refX [NW];
    logic [W-1:0] refY [NW];

    logic         forceNotReady = 1'b0;
    int           stubSteps;
    logic [2:0]   stubRes;
    logic [2:0]   stubNext;

    compare_feeder #(.iW(W), .NWORDS(NW)) dut (
        .iClk(iClk), .iReset(iReset), .iLoadValid(iLoadValid), .iLoadSel(iLoadSel),
        .iLoadAddr(iLoadAddr), .iLoadData(iLoadData), .iStart(iStart), .oBusy(oBusy),
        .oCmpEnable(oCmpEnable), .oCmpDataX(oCmpDataX), .oCmpDataY(oCmpDataY),
        .iCmpMode(iCmpMode), .oResultValid(oResultValid), .oResult(oResult), .oError(oError)
    );

    always #5 iClk = ~iClk;

    // Serial comparator: a later (more significant) differing word overrides earlier ones.
    always_comb begin
        stubNext = stubRes;
        if (oCmpDataX < oCmpDataY)      stubNext = 3'b010;
        else if (oCmpDataX > oCmpDataY) stubNext = 3'b001;
    end

    always @(posedge iClk) begin
        if (!oCmpEnable) begin
            stubSteps <= 0;
            stubRes   <= 3'b011;
            iCmpMode  <= 3'b000;
        end else if (stubSteps < NW) begin
            stubRes   <= stubNext;
            stubSteps <= stubSteps + 1;
            iCmpMode  <= (stubSteps == NW-1 && !forceNotReady) ? stubNext : 3'b000;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Verdict from the operand values: the most significant differing word decides.
    function automatic logic [1:0] refVerdict();
        for (int i = NW-1; i >= 0; i--)
            if (refX[i] != refY[i]) return (refX[i] < refY[i]) ? 2'b10 : 2'b01;
        return 2'b11;
    endfunction

    task automatic loadAll();
        for (int i = 0; i < NW; i++) begin
            iLoadValid = 1'b1; iLoadSel = 1'b0; iLoadAddr = 6'(i); iLoadData = refX[i];
            step();
            iLoadSel = 1'b1; iLoadData = refY[i];
            step();
        end
        iLoadValid = 1'b0;
    endtask

    task automatic runCompare(input string tag, input bit loadX0, input logic [W-1:0] newX0,
                              input bit loadInRun);
        int badCtl, badData;
        logic [1:0] expRes;
        logic       expErr;
        badCtl = 0; badData = 0;
        iStart = 1'b1;
        if (loadX0) begin
            iLoadValid = 1'b1; iLoadSel = 1'b0; iLoadAddr = 6'd0; iLoadData = newX0;
        end
        step();
        iStart = 1'b0; iLoadValid = 1'b0;
        if (loadX0) refX[0] = newX0;
        expRes = forceNotReady ? 2'b00 : refVerdict();
        expErr = forceNotReady;
        for (int k = 0; k <= NW; k++) begin
            if (oCmpEnable !== 1'b1 || oBusy !== 1'b1 || oResultValid !== 1'b0) badCtl++;
            if (k < NW && (oCmpDataX !== refX[k] || oCmpDataY !== refY[k])) badData++;
            if (k == 0) check({tag, " run0 dataX"}, 64'(oCmpDataX), 64'(refX[0]));
            if (loadInRun && k == 5) begin
                iLoadValid = 1'b1; iLoadSel = 1'b0; iLoadAddr = 6'd0; iLoadData = 32'hFFFF;
            end
            step();
            iLoadValid = 1'b0;
        end
        check({tag, " run control"}, 64'(badCtl), 64'd0);
        check({tag, " run data"}, 64'(badData), 64'd0);
        check({tag, " valid at +66"}, 64'(oResultValid), 64'd1);
        check({tag, " result"}, 64'(oResult), 64'(expRes));
        check({tag, " error"}, 64'(oError), 64'(expErr));
        check({tag, " done enable"}, 64'(oCmpEnable), 64'd0);
        step();
        check({tag, " single valid"}, 64'(oResultValid), 64'd0);
        check({tag, " idle busy"}, 64'(oBusy), 64'd0);
        check({tag, " result held"}, 64'({oResult, oError}), 64'({expRes, expErr}));
    endtask

    initial begin
        int validCycles[$];
        int nValid, badRes;
        iReset = 1'b1; iLoadValid = 1'b0; iLoadSel = 1'b0; iLoadAddr = '0;
        iLoadData = '0; iStart = 1'b0;
        repeat (3) step();
        check("reset busy",   64'(oBusy), 64'd0);
        check("reset enable", 64'(oCmpEnable), 64'd0);
        check("reset valid",  64'(oResultValid), 64'd0);
        check("reset result", 64'({oResult, oError}), 64'd0);
        check("reset data",   64'({oCmpDataX, oCmpDataY}), 64'd0);
        iReset = 1'b0;
        step();

        // All-ones operands compare equal.
        for (int i = 0; i < NW; i++) begin refX[i] = '1; refY[i] = '1; end
        loadAll();
        runCompare("ones", 0, '0, 0);

        // Most significant word outranks an opposite difference in word 0.
        for (int i = 0; i < NW; i++) begin refX[i] = $urandom; refY[i] = refX[i]; end
        refX[63] = 1; refY[63] = 2; refX[0] = 9; refY[0] = 0;
        loadAll();
        runCompare("msw", 0, '0, 0);

        // Start held high: back-to-back compares every 67 cycles.
        for (int i = 0; i < NW; i++) begin refX[i] = $urandom; refY[i] = refX[i]; end
        refX[5] = 7; refY[5] = 3;
        loadAll();
        badRes = 0;
        for (int c = 1; c <= 220; c++) begin
            iStart = (c <= 200);
            step();
            if (oResultValid === 1'b1) begin
                validCycles.push_back(c);
                if (oResult !== 2'b01 || oError !== 1'b0) badRes++;
            end
        end
        iStart = 1'b0;
        nValid = validCycles.size();
        check("b2b count", 64'(nValid), 64'd3);
        if (nValid == 3) begin
            check("b2b first", 64'(validCycles[0]), 64'd66);
            check("b2b period1", 64'(validCycles[1] - validCycles[0]), 64'd67);
            check("b2b period2", 64'(validCycles[2] - validCycles[1]), 64'd67);
        end
        check("b2b results", 64'(badRes), 64'd0);

        // Comparator never ready: protocol error.
        forceNotReady = 1'b1;
        runCompare("notready", 0, '0, 0);
        forceNotReady = 1'b0;

        // Reset during RUN cycle 30 aborts without a result.
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        repeat (30) step();
        #2 iReset = 1'b1;
        #1;
        check("abort enable", 64'(oCmpEnable), 64'd0);
        check("abort busy",   64'(oBusy), 64'd0);
        check("abort result", 64'({oResult, oError}), 64'd0);
        check("abort data",   64'({oCmpDataX, oCmpDataY}), 64'd0);
        step();
        iReset = 1'b0;
        nValid = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (oResultValid === 1'b1) nValid++;
        end
        check("abort no valid", 64'(nValid), 64'd0);
        runCompare("restart", 0, '0, 0);

        // Loads during RUN are dropped; a load on the accepting edge is used.
        runCompare("runload", 0, '0, 1);
        runCompare("runload verify", 0, '0, 0);
        runCompare("sameedge", 1, $urandom, 0);

        // Randomized operands with zero, one or several differing words.
        for (int t = 0; t < 6; t++) begin
            int nd;
            for (int i = 0; i < NW; i++) begin refX[i] = $urandom; refY[i] = refX[i]; end
            nd = $urandom_range(0, 3);
            for (int d = 0; d < nd; d++) refY[$urandom_range(0, NW-1)] = $urandom;
            loadAll();
            runCompare($sformatf("rand%0d", t), 0, '0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
